fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that produces the PC, PC+4 and instruction consumed by the IF/ID pipeline register. It holds the fetch PC, issues one request at a time to instruction memory over a req/ready + rvalid handshake, and buffers returned instructions in a small in-order queue so downstream stalls do not lose fetched words. Branch/jump redirects from EX flush the queue and restart fetch, dropping any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTRUCTION, 32'h0000_0013, instruction driven when queue empty
- QUEUE_DEPTH, 2, fetch queue entries (power of 2, >=2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- redirect  in  1  branch/jump taken; restart fetch at redirect_pc
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 0
- stall  in  1  downstream not accepting (IF/ID enable low)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (word aligned)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid (in order, >=1 cycle after accept)
- imem_rdata  in  32  returned instruction
- if_valid  out  1  queue head valid
- if_pc  out  32  PC of queue head
- if_pc_plus_4  out  32  if_pc + 4
- if_instruction  out  32  instruction of queue head

## Operation
- State: fetch_pc (32), FSM {IDLE, WAIT, DISCARD}, queue of {pc, instr}, count 0..QUEUE_DEPTH.
- Reset: fetch_pc=RESET_PC, state=IDLE, count=0; imem_req=0 in reset cycles.
- Accept = imem_req && imem_ready. Memory tolerates withdrawal/address change of an unaccepted request.
- pop = if_valid && !stall && !redirect; push = state==WAIT && imem_rvalid && !redirect.
- imem_req = !rst && !redirect && (state==IDLE || (state==WAIT && imem_rvalid)) && (count + push - pop) < QUEUE_DEPTH. imem_addr = fetch_pc always.
- On accept: fetch_pc <= fetch_pc+4 (wraps mod 2^32); state -> WAIT; request's PC latched as pending_pc.
- WAIT: on imem_rvalid, write {pending_pc, imem_rdata} at tail; state -> IDLE unless a new request accepted same cycle (stay WAIT).
- DISCARD: on imem_rvalid drop data, -> IDLE; no request issued that cycle.
- IDLE: imem_rvalid ignored.
- Redirect (highest priority, overrides stall): count <= 0, fetch_pc <= {redirect_pc[31:2],2'b00}; WAIT -> DISCARD (WAIT with rvalid same cycle -> IDLE, data dropped); DISCARD stays; IDLE stays. No request that cycle.
- Outputs combinational from queue head: count>0 -> if_valid=1, head pc/pc+4/instr; count==0 -> if_valid=0, if_pc=0, if_pc_plus_4=0, if_instruction=NOP_INSTRUCTION.
- Simultaneous push+pop: count unchanged; push into full queue is impossible by construction (assert).

## Timing
- Reset output values: if_valid=0, if_pc=0, if_pc_plus_4=0, if_instruction=NOP_INSTRUCTION, imem_req=0, imem_addr=RESET_PC.
- First cycle after rst falls: imem_req=1, imem_addr=RESET_PC.
- Response in cycle N -> if_valid with that instruction in cycle N+1 (no bypass).
- 1-cycle memory, always ready, no stalls: one instruction per cycle sustained.
- Stall: head held stable on outputs for the whole stall; fetching continues until queue full, then imem_req=0.
- Redirect in cycle N: cycle N+1 if_valid=0, request to target issued N+1 if state IDLE, else after discarded response arrives.
- rst mid-operation: all state reinitialized next edge; memory is reset by same rst, so no stale responses.

## Test plan
- Reset release, ready=1, 1-cycle latency -> addrs 0x0,0x4,0x8 on consecutive cycles; if_valid from cycle 2 with if_pc 0x0, if_pc_plus_4 0x4.
- stall held 5 cycles -> outputs frozen on same entry; imem_req drops after 2 buffered entries; release -> entries drain in order, no loss/duplication.
- Redirect to 0x103 while WAIT (latency 3) -> late response dropped, next imem_addr 0x100, first if_pc 0x100.
- Redirect same cycle as imem_rvalid and stall=1 -> queue empty next cycle, data dropped, request at target next cycle.
- imem_ready low 4 cycles -> imem_req held, if_valid=0 with if_instruction=0x00000013 once queue drains.
- Redirect to 0xFFFFFFFC -> if_pc_plus_4=0x0, next fetch address 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request at a time, returned words buffered in a
// small in-order queue that feeds IF/ID. Redirects flush the queue and drop in-flight data.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013,
  parameter int unsigned QUEUE_DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instruction
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     qpc_q [QUEUE_DEPTH];
  logic [31:0]     qpc_d [QUEUE_DEPTH];
  logic [31:0]     qins_q [QUEUE_DEPTH];
  logic [31:0]     qins_d [QUEUE_DEPTH];

  logic            push, pop, accept;
  logic [CntW:0]   count_after;

  // Handshake: a new request is only allowed when its response is guaranteed a queue slot.
  always_comb begin
    if_valid    = (count_q != '0);
    pop         = if_valid && !stall && !redirect;
    push        = (state_q == StWait) && imem_rvalid && !redirect;
    count_after = {1'b0, count_q} + {{CntW{1'b0}}, push} - {{CntW{1'b0}}, pop};
    imem_req    = !rst && !redirect
                  && ((state_q == StIdle) || ((state_q == StWait) && imem_rvalid))
                  && (count_after < DepthExt);
    accept      = imem_req && imem_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StWait;
      StWait:    if (imem_rvalid) state_d = accept ? StWait : StIdle;
      StDiscard: if (imem_rvalid) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // A response still owed by memory must be swallowed before fetching the new target.
    if (redirect) begin
      state_d = ((state_q != StIdle) && !imem_rvalid) ? StDiscard : StIdle;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_after[CntW-1:0];
    qpc_d        = qpc_q;
    qins_d       = qins_q;
    if (accept) begin
      fetch_pc_d   = fetch_pc_q + 32'd4;
      pending_pc_d = fetch_pc_q;
    end
    if (push) begin
      qpc_d[tail_q]  = pending_pc_q;
      qins_d[tail_q] = imem_rdata;
      tail_d         = tail_q + PtrW'(1);
    end
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    qpc_q  <= qpc_d;
    qins_q <= qins_d;
  end

  always_comb begin
    imem_addr      = fetch_pc_q;
    if_pc          = '0;
    if_pc_plus_4   = '0;
    if_instruction = NOP_INSTRUCTION;
    if (if_valid) begin
      if_pc          = qpc_q[head_q];
      if_pc_plus_4   = qpc_q[head_q] + 32'd4;
      if_instruction = qins_q[head_q];
    end
  end

  push_into_full_a : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CntW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_pc_plus_4, if_instruction;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .NOP_INSTRUCTION(NOP),
    .QUEUE_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pc_plus_4  (if_pc_plus_4),
    .if_instruction(if_instruction)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Memory model: single outstanding request, fixed latency chosen at accept time.
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;

  task automatic mem_update();
    if (rst) begin
      mem_busy = 1'b0;
    end else begin
      if (imem_rvalid) mem_busy = 1'b0;
      if (imem_req && imem_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = mem_lat - 1;
      end
    end
  endtask

  // Close the previous cycle, drive the next one, return at its falling edge.
  task automatic cyc(input logic r_rst, input logic r_redir, input logic [31:0] r_pc,
                     input logic r_stall, input logic r_ready);
    mem_update();
    @(posedge clk);
    #1;
    rst         = r_rst;
    redirect    = r_redir;
    redirect_pc = r_pc;
    stall       = r_stall;
    imem_ready  = r_ready;
    if (!r_rst && mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_busy && mem_cnt > 0) mem_cnt--;
    end
    @(negedge clk);
  endtask

  // Behavioural model: FIFO of fetched words, next fetch PC, and the one request memory owes.
  logic [31:0] m_qpc[$];
  logic [31:0] m_qins[$];
  logic [31:0] m_fpc, m_ppc;
  bit          m_live = 1'b0;
  bit          m_owed = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_push, m_pop, m_req;
  int          m_sz;

  always @(negedge clk) begin
    m_sz   = m_qpc.size();
    m_pop  = (m_sz != 0) && !stall && !redirect;
    m_push = m_owed && !m_drop && imem_rvalid && !redirect;
    m_req  = !rst && !redirect && (!m_owed || (imem_rvalid && !m_drop))
             && (m_sz + int'(m_push) - int'(m_pop) < int'(DEPTH));
    if (m_live) begin
      check("model if_valid", {31'b0, if_valid}, {31'b0, m_sz != 0});
      check("model if_pc", if_pc, (m_sz != 0) ? m_qpc[0] : 32'h0);
      check("model if_pc_plus_4", if_pc_plus_4, (m_sz != 0) ? m_qpc[0] + 32'd4 : 32'h0);
      check("model if_instruction", if_instruction, (m_sz != 0) ? m_qins[0] : NOP);
      check("model imem_req", {31'b0, imem_req}, {31'b0, m_req});
      check("model imem_addr", imem_addr, m_fpc);
    end
    if (rst) begin
      m_qpc.delete();
      m_qins.delete();
      m_fpc  = 32'h0;
      m_owed = 1'b0;
      m_drop = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (redirect) begin
        m_qpc.delete();
        m_qins.delete();
        m_fpc = {redirect_pc[31:2], 2'b00};
        if (m_owed) begin
          if (imem_rvalid) m_owed = 1'b0;
          else             m_drop = 1'b1;
        end
      end else begin
        if (m_pop) begin
          void'(m_qpc.pop_front());
          void'(m_qins.pop_front());
        end
        if (m_push) begin
          m_qpc.push_back(m_ppc);
          m_qins.push_back(imem_rdata);
        end
        if (m_owed && imem_rvalid) begin
          m_owed = 1'b0;
          m_drop = 1'b0;
        end
        if (m_req && imem_ready) begin
          m_owed = 1'b1;
          m_drop = 1'b0;
          m_ppc  = m_fpc;
          m_fpc  = m_fpc + 32'd4;
        end
      end
    end
  end

  bit found;

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    check("reset imem_req", {31'b0, imem_req}, 32'h0);
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset if_valid", {31'b0, if_valid}, 32'h0);
    check("reset if_pc", if_pc, 32'h0);
    check("reset if_instruction", if_instruction, NOP);

    // Streaming: 1-cycle memory, always ready
    mem_lat = 1;
    cyc(0, 0, 0, 0, 1);
    check("c0 imem_req", {31'b0, imem_req}, 32'h1);
    check("c0 imem_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 1);
    check("c1 imem_addr", imem_addr, 32'h4);
    check("c1 if_valid", {31'b0, if_valid}, 32'h0);
    cyc(0, 0, 0, 0, 1);
    check("c2 imem_addr", imem_addr, 32'h8);
    check("c2 if_valid", {31'b0, if_valid}, 32'h1);
    check("c2 if_pc", if_pc, 32'h0);
    check("c2 if_pc_plus_4", if_pc_plus_4, 32'h4);
    check("c2 if_instruction", if_instruction, mem_word(32'h0));

    // Stall for 5 cycles: head frozen, fetching stops once 2 entries are buffered
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 1);
      check("stall if_pc", if_pc, 32'h4);
      check("stall if_instruction", if_instruction, mem_word(32'h4));
      check("stall imem_req", {31'b0, imem_req}, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("drain if_pc", if_pc, 32'h4 + 32'(4 * i));
    end

    // Redirect while a 3-cycle request is outstanding
    mem_lat = 3;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cyc(0, 0, 0, 0, 1);
      if (imem_req && imem_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("redir3 accept seen", {31'b0, found}, 32'h1);
    cyc(0, 1, 32'h103, 0, 1);
    check("redir3 no req on redirect", {31'b0, imem_req}, 32'h0);
    cyc(0, 0, 0, 0, 1);
    check("redir3 if_valid", {31'b0, if_valid}, 32'h0);
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (imem_req) begin
        found = 1'b1;
        break;
      end
      cyc(0, 0, 0, 0, 1);
    end
    check("redir3 req timeout", {31'b0, found}, 32'h1);
    check("redir3 target addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (if_valid) begin
        found = 1'b1;
        break;
      end
      cyc(0, 0, 0, 0, 1);
    end
    check("redir3 if_valid timeout", {31'b0, found}, 32'h1);
    check("redir3 first if_pc", if_pc, 32'h100);

    // Redirect coinciding with a response while stalled
    mem_lat = 1;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cyc(0, 0, 0, 0, 1);
      if (imem_req && imem_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("redir_rv accept seen", {31'b0, found}, 32'h1);
    cyc(0, 1, 32'h200, 1, 1);
    cyc(0, 0, 0, 1, 1);
    check("redir_rv if_valid", {31'b0, if_valid}, 32'h0);
    check("redir_rv imem_req", {31'b0, imem_req}, 32'h1);
    check("redir_rv imem_addr", imem_addr, 32'h200);

    // Memory not ready for 4 cycles: request held, queue drains to NOP
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("noready imem_req", {31'b0, imem_req}, 32'h1);
      check("noready imem_addr", imem_addr, 32'h204);
    end
    check("noready if_valid", {31'b0, if_valid}, 32'h0);
    check("noready if_instruction", if_instruction, NOP);

    // Redirect to the top of the address space: PC wraps
    cyc(0, 1, 32'hFFFF_FFFC, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("wrap imem_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    check("wrap next imem_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 1);
    check("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap if_pc_plus_4", if_pc_plus_4, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      mem_lat = $urandom_range(1, 4);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), $urandom,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
